// File: rtl/ascon_pkg.sv
// Shared codes, rates and FSM encodings for the Ascon absorb feeder.
// Imported by the feeder top and its word packer.
package ascon_pkg;

  typedef enum logic [1:0] {
    SEL_AEAD128 = 2'b00,
    SEL_HASH256 = 2'b01,
    SEL_XOF128  = 2'b10,
    SEL_CXOF128 = 2'b11
  } sel_t;

  localparam logic [4:0] RATE_AEAD = 5'd16;
  localparam logic [4:0] RATE_HASH = 5'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_ISSUE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  function automatic logic [4:0] rate_of(
    input logic [1:0] sel
  );
    return (sel == SEL_AEAD128) ? RATE_AEAD : RATE_HASH;
  endfunction

endpackage

// File: rtl/ascon_word_packer.sv
// Writes one masked 32-bit word into its slot of a 128-bit block.
// Bytes at or beyond the block byte count are forced to zero.
module ascon_word_packer (
  input  logic [127:0] blk_in,
  input  logic [1:0]   idx,
  input  logic [4:0]   bc,
  input  logic [31:0]  word,
  output logic [127:0] blk_out
);

  logic [4:0]  base;
  logic [31:0] mword;

  // mask the word by byte position, then drop it into slot idx
  always_comb begin
    base    = {1'b0, idx, 2'b00};
    mword   = '0;
    blk_out = blk_in;
    for (int b = 0; b < 4; b++) begin
      if ((base + 5'(b)) < bc)
        mword[8*b +: 8] = word[8*b +: 8];
    end
    blk_out[{idx, 5'b00000} +: 32] = mword;
  end

endmodule

// File: rtl/ascon_absorb_feeder.sv
// Packs a 32-bit word stream into Ascon rate blocks with a final pad block.
// Optional sticky protocol error flag: define ASCON_FEEDER_ERR_EN.
module ascon_absorb_feeder #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        sel_type,
  input  logic [31:0]       msg_len,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              blk_ready,
  output logic              process_en,
  output logic [127:0]      data,
  output logic [31:0]       data_length,
  output logic [31:0]       data_position,
  output logic              busy,
  output logic              done
`ifdef ASCON_FEEDER_ERR_EN
  ,
  output logic              err
`endif
);

  import ascon_pkg::*;

  state_t       state;
  logic [1:0]   sel_q;
  logic [2:0]   wcnt;
  logic [2:0]   wnext;
  logic [4:0]   rate;
  logic [31:0]  rate32;
  logic [31:0]  rem;
  logic         last;
  logic [4:0]   bc;
  logic [4:0]   bc3;
  logic [2:0]   wn;
  logic         acc;
  logic [127:0] packed_blk;

  // block geometry for the current position
  always_comb begin
    rate   = rate_of(sel_q);
    rate32 = {27'd0, rate};
    rem    = data_length - data_position;
    last   = rem < rate32;
    bc     = last ? rem[4:0] : rate;
    bc3    = bc + 5'd3;
    wn     = bc3[4:2];
    in_ready = (state == ST_FILL) && (wcnt < wn);
    acc    = in_valid & in_ready;
    wnext  = wcnt + {2'b00, acc};
  end

  // the strobe lands in the same cycle the absorb stage reports free
  assign process_en = (state == ST_ISSUE) & blk_ready;

  ascon_word_packer u_packer (
    .blk_in  (data),
    .idx     (wcnt[1:0]),
    .bc      (bc),
    .word    (in_data[31:0]),
    .blk_out (packed_blk)
  );

  // block sequencer; zero-word blocks skip FILL and go straight to ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      sel_q         <= 2'b00;
      wcnt          <= 3'd0;
      data          <= '0;
      data_length   <= '0;
      data_position <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sel_q         <= sel_type;
            data_length   <= msg_len;
            data_position <= '0;
            data          <= '0;
            wcnt          <= 3'd0;
            busy          <= 1'b1;
            state <= (msg_len == 32'd0) ? ST_ISSUE : ST_FILL;
          end
        end
        ST_FILL: begin
          if (acc) begin
            data <= packed_blk;
            wcnt <= wnext;
          end
          if (wnext == wn)
            state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (blk_ready) begin
            if (last) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              data_position <= data_position + {27'd0, bc};
              data          <= '0;
              wcnt          <= 3'd0;
              state <= (rem == rate32) ? ST_ISSUE : ST_FILL;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ASCON_FEEDER_ERR_EN
  // sticky misuse flag, cleared only by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (state == ST_IDLE && start)
      err <= 1'b0;
    else if ((in_valid && (state == ST_IDLE || state == ST_DONE)) ||
             (start && state != ST_IDLE))
      err <= 1'b1;
  end
`endif

endmodule
